// File: rtl/serial_byte_rx.sv
// serial_byte_rx: strobed serial-to-parallel word receiver with sync framing,
// a single-entry holding register, and sticky overrun / sync error flags.
module serial_byte_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic             overrun,
  output logic             sync_err,
  input  logic             clr_err,
  output logic             locked
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {HUNT = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, idx, pos;
  logic             take, word_done, serr_set, ovr_set;

  // Next-state: pick the bit index for this strobe, insert sin, detect completion
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    take      = 1'b0;
    word_done = 1'b0;
    serr_set  = 1'b0;
    idx       = '0;
    case (state)
      HUNT: begin
        if (shift_en && sync) begin
          take      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          take = 1'b1;
          // sync mid-word restarts framing; sync at a word boundary is benign
          if (sync && cnt != '0) serr_set = 1'b1;
          else                   idx      = cnt;
        end
      end
      default: state_nxt = HUNT;
    endcase
    pos = MSB_FIRST ? (CW'(WIDTH-1) - idx) : idx;
    if (take) begin
      sreg_nxt[pos] = sin;
      if (idx == CW'(WIDTH-1)) begin
        word_done = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = idx + CW'(1);
      end
    end
  end

  // A completed word is dropped only if the holding register is full and not being drained
  assign ovr_set = word_done && dout_valid && !dout_ack;

  // FSM, bit counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Holding register: load on completion when free or acked this edge, else clear on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (word_done && (!dout_valid || dout_ack)) begin
      dout       <= sreg_nxt;
      dout_valid <= 1'b1;
    end else if (dout_ack && !word_done) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set on the same edge as clr_err takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overrun  <= ovr_set  | (overrun  & ~clr_err);
      sync_err <= serr_set | (sync_err & ~clr_err);
    end
  end

  assign locked = (state == SHIFT);

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: directed and randomized checks of serial_byte_rx against a
// queue-based reference model; MSB-first and LSB-first instances share stimulus.
module tb_serial_byte_rx;

  localparam int W = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic         sin = 1'b0, shift_en = 1'b0, sync = 1'b0, dout_ack = 1'b0, clr_err = 1'b0;
  logic [W-1:0] dout, dout_l;
  logic         dout_valid, overrun, sync_err, locked;
  logic         dv_l, ov_l, se_l, lk_l;

  int n_chk = 0, n_err = 0;

  // model state
  bit           mbits[$];
  bit           m_locked;
  logic [W-1:0] e_dout, e_dout_l;
  logic         e_valid, e_ovr, e_serr;

  logic [2*W+7:0] obs;
  assign obs = {dout, dout_l, dout_valid, dv_l, overrun, ov_l, sync_err, se_l, locked, lk_l};

  always #5 clk = ~clk;

  serial_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin), .shift_en(shift_en), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ack(dout_ack), .overrun(overrun),
    .sync_err(sync_err), .clr_err(clr_err), .locked(locked)
  );

  serial_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .shift_en(shift_en), .sync(sync),
    .dout(dout_l), .dout_valid(dv_l), .dout_ack(dout_ack), .overrun(ov_l),
    .sync_err(se_l), .clr_err(clr_err), .locked(lk_l)
  );

  function automatic logic [2*W+7:0] exp_vec();
    return {e_dout, e_dout_l, e_valid, e_valid, e_ovr, e_ovr, e_serr, e_serr, m_locked, m_locked};
  endfunction

  function automatic void model_reset();
    mbits.delete();
    m_locked = 1'b0;
    e_dout = '0; e_dout_l = '0;
    e_valid = 1'b0; e_ovr = 1'b0; e_serr = 1'b0;
  endfunction

  // one clock edge of the receiver, expressed as a list of bits since the word start
  function automatic void model_edge(input logic s, input logic e, input logic y,
                                     input logic a, input logic c);
    logic [W-1:0] wm, wl;
    bit done, serr, ovr;
    wm = '0; wl = '0; done = 0; serr = 0; ovr = 0;
    if (e) begin
      if (!m_locked) begin
        if (y) begin mbits = {s}; m_locked = 1'b1; end
      end else if (y && mbits.size() != 0) begin
        serr = 1; mbits = {s};
      end else begin
        mbits.push_back(s);
      end
      if (mbits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mbits[i];
          wl[i]     = mbits[i];
        end
        done = 1;
        mbits.delete();
      end
    end
    if (done && (!e_valid || a)) begin
      e_dout = wm; e_dout_l = wl; e_valid = 1'b1;
    end else if (done) begin
      ovr = 1;
    end else if (a) begin
      e_valid = 1'b0;
    end
    e_ovr  = ovr  | (e_ovr  & !c);
    e_serr = serr | (e_serr & !c);
  endfunction

  task automatic step(input logic s, input logic e, input logic y, input logic a, input logic c);
    @(negedge clk);
    sin = s; shift_en = e; sync = y; dout_ack = a; clr_err = c;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(s, e, y, a, c);
    #1;
  endtask

  // word v is sent v[W-1] first; optional sync on first bit, random gaps, ack on last edge
  task automatic send_word(input logic [W-1:0] v, input bit syn, input int maxgap, input bit ack_last);
    for (int i = 0; i < W; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int k = 0; k < g; k++) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(v[W-1-i], 1'b1, syn && (i == 0), ack_last && (i == W-1), 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (obs !== '0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_no_sync();
    for (int i = 0; i < 16; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (locked !== 1'b0 || dout_valid !== 1'b0 || obs !== exp_vec()) begin
        n_err++; $display("FAIL no_sync bit %0d: locked=%b valid=%b obs=%h expected %h",
                          i, locked, dout_valid, obs, exp_vec());
      end
    end
  endtask

  task automatic test_word();
    send_word(8'hA5, 1'b1, 0, 1'b0);
    n_chk++;
    if (dout !== 8'hA5 || dout_l !== 8'hA5 || dout_valid !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL word_a5: dout=%h dout_lsb=%h valid=%b expected a5/a5/1", dout, dout_l, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (dout_valid !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL ack_clears_valid: valid=%b expected 0", dout_valid);
    end
    send_word(8'hC0, 1'b1, 0, 1'b0);
    n_chk++;
    if (dout !== 8'hC0 || dout_l !== 8'h03 || sync_err !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL word_c0: dout=%h dout_lsb=%h sync_err=%b expected c0/03/0", dout, dout_l, sync_err);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 1'b0, 0, 1'b0);
    send_word(8'hC3, 1'b0, 0, 1'b0);
    n_chk++;
    if (dout !== 8'h3C || overrun !== 1'b1 || dout_valid !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL overrun: dout=%h overrun=%b valid=%b expected 3c/1/1", dout, overrun, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (overrun !== 1'b0 || dout_valid !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL clr_overrun: overrun=%b valid=%b expected 0/1", overrun, dout_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ack_same_edge();
    send_word(8'h18, 1'b0, 0, 1'b0);
    send_word(8'h81, 1'b0, 0, 1'b1);
    n_chk++;
    if (dout !== 8'h81 || dout_valid !== 1'b1 || overrun !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL ack_same_edge: dout=%h valid=%b overrun=%b expected 81/1/0", dout, dout_valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sync_err();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (sync_err !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL sync_at_boundary: sync_err=%b expected 0", sync_err);
    end
    send_word(8'h5A, 1'b1, 0, 1'b0);
    n_chk++;
    if (sync_err !== 1'b1 || dout !== 8'h5A || dout_valid !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL sync_err_word: sync_err=%b dout=%h expected 1/5a", sync_err, dout);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (sync_err !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL set_beats_clr: sync_err=%b expected 1", sync_err);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (sync_err !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL clr_sync_err: sync_err=%b expected 0", sync_err);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sin = 1'b0; shift_en = 1'b0; sync = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (obs !== '0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL async_reset: got %h expected 0", obs);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    send_word(8'hFF, 1'b0, 4, 1'b0);
    n_chk++;
    if (locked !== 1'b0 || dout_valid !== 1'b0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL hunt_after_reset: locked=%b valid=%b expected 0/0", locked, dout_valid);
    end
    send_word(8'h96, 1'b1, 4, 1'b0);
    n_chk++;
    if (dout !== 8'h96 || dout_l !== 8'h69 || dout_valid !== 1'b1 || locked !== 1'b1 || obs !== exp_vec()) begin
      n_err++; $display("FAIL gapped_word: dout=%h dout_lsb=%h valid=%b locked=%b expected 96/69/1/1",
                        dout, dout_l, dout_valid, locked);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom % 100) < 70, ($urandom % 100) < 8,
           ($urandom % 100) < 30, ($urandom % 100) < 5);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_sync();
    test_word();
    test_overrun();
    test_ack_same_edge();
    test_sync_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_byte_rx.md
SERIAL_BYTE_RX -- requirements
Module: serial_byte_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per word (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].
REQ-003 The port list SHALL be, in order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sin  in  1  serial data bit, sampled on rising edges where shift_en=1.
- shift_en  in  1  bit strobe; when 0, no bit is taken that cycle.
- sync  in  1  word marker, qualified by shift_en; the bit sampled on the same edge is bit 0 of a new word.
- dout  out  WIDTH  last completed word.
- dout_valid  out  1  dout holds an unacknowledged word.
- dout_ack  in  1  consumer accepts dout on a rising edge where dout_valid=1.
- overrun  out  1  sticky: a word completed while dout_valid=1 and it was not acked.
- sync_err  out  1  sticky: sync arrived with a partial word pending.
- clr_err  in  1  synchronous clear of overrun and sync_err.
- locked  out  1  FSM is in SHIFT.

Function
REQ-004 The FSM SHALL have two states, HUNT and SHIFT.
- HUNT: sin is ignored until an edge with shift_en=1 and sync=1.
- That edge stores sin as bit 0, sets bit count to 1, and moves to SHIFT.
REQ-005 In SHIFT, each edge with shift_en=1 and sync=0 SHALL store sin into the shift register at the position given by MSB_FIRST and increment the bit count.
REQ-006 Word completion is the edge that takes bit WIDTH-1. On that edge:
- the assembled word is written to the holding register (driving dout);
- dout_valid is set;
- the bit count returns to 0;
- the FSM stays in SHIFT.
dout is therefore valid in the cycle after the last bit's edge, a latency of 1 clock.
REQ-007 After completion, the next shift_en edge SHALL start a new word, whether or not sync=1 (free-running framing). sync=1 with count=0 is legal and is not an error.
REQ-008 If shift_en=1 and sync=1 in SHIFT with bit count not 0:
- the partial word is discarded;
- sync_err is set;
- sin is taken as bit 0 of a new word with count=1.
REQ-009 dout_valid SHALL clear on an edge where dout_valid=1, dout_ack=1, and no word completes.
REQ-010 If a word completes on the same edge as a valid ack, the new word SHALL be loaded and dout_valid SHALL remain 1, with no overrun.
REQ-011 If a word completes while dout_valid=1 and dout_ack=0:
- the holding register keeps the old word;
- the new word is dropped;
- overrun is set;
- dout_valid stays 1.
REQ-012 dout_ack while dout_valid=0 SHALL have no effect.
REQ-013 When shift_en=0, the shift register, bit count and FSM state SHALL hold. dout_ack and clr_err remain effective.
REQ-014 On clr_err=1, overrun and sync_err SHALL clear. If a set condition occurs on the same edge, set wins.
REQ-015 The bit count SHALL be clog2(WIDTH) bits wide. It wraps only through REQ-006; values of WIDTH or above SHALL be unreachable.
REQ-016 locked SHALL be 1 exactly when the FSM is in SHIFT. It is a registered output.

Reset
REQ-017 While reset=1, the following SHALL hold independent of clk:
- FSM = HUNT;
- shift register = 0 and bit count = 0;
- dout = 0, dout_valid = 0, overrun = 0, sync_err = 0, locked = 0.
REQ-018 A reset asserted in the middle of a word SHALL discard the partial word. After release, the block needs a new sync to leave HUNT.
REQ-019 On the first rising edge after reset falls, the block SHALL respond normally to inputs on that edge.

Verification
REQ-020 Reset, then 16 strobed bits with sync=0 -> locked=0 and dout_valid=0 throughout.
REQ-021 WIDTH=8, MSB_FIRST=1: sync on the first bit, bits 1,0,1,0,0,1,0,1 -> dout=8'hA5 and dout_valid=1 one cycle after the 8th edge. With MSB_FIRST=0 the same stream -> dout=8'hA5 as well (palindromic check); 1,1,0,0,0,0,0,0 -> 8'h03.
REQ-022 Send 8'h3C and leave it un-acked, then send 8'hC3 -> dout stays 8'h3C, overrun=1. Pulse clr_err -> overrun=0.
REQ-023 Assert ack on the same edge as a completing 8'h81 -> dout=8'h81, dout_valid stays 1, overrun=0.
REQ-024 sync after 3 bits -> sync_err=1. The next 8 bits starting at that sync give the correct word.
REQ-025 reset pulse after 5 bits, then shift_en bursts with gaps (shift_en=0 for 1..4 cycles between bits) -> HUNT until sync; with gaps, the word still assembles correctly.
